rv_mc_sequencer: RTL and testbench
==================================

# rv_mc_sequencer

Parametrised multi-cycle control sequencer for the RISC-V core. It replaces the flat, single-cycle wiring of fetch, decode, register file and ALU with an explicit fetch/decode/execute/memory/writeback state machine. It performs ready/valid handshakes with instruction memory, data memory and the ALU, owns the PC, counts retired instructions, and reports run/halt/fault status. It sits between the instruction/data memories and the datapath blocks (decoder, register file, ALU) inside the core top level.

## Interface
- PC_WIDTH, 32, program counter and address width
- I_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- RETIRE_W, 32, width of the retired-instruction counter
- TIMEOUT_W, 8, width of the wait-timeout counter; fault after 2**TIMEOUT_W-1 wait cycles
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_WIDTH  fetch address (equals PC)
- imem_valid  in  1  fetch data valid
- imem_rdata  in  I_WIDTH  fetched instruction
- instr  out  I_WIDTH  latched instruction register, feeds the decoder
- is_alu, is_load, is_store, is_branch  in  1 each  decoder class flags for instr
- illegal  in  1  decoder reports an unsupported instruction
- branch_taken  in  1  branch/jump resolved taken (valid in EXEC)
- branch_target  in  PC_WIDTH  taken target address
- alu_start  out  1  one-cycle ALU start pulse
- alu_done  in  1  ALU result valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
- dmem_ack  in  1  data access complete
- rf_we  out  1  register file write enable, one cycle
- halt_req  in  1  request to stop at the next instruction boundary
- running  out  1  high in every state except HALT and FAULT
- fault  out  1  sticky fault flag
- retired  out  RETIRE_W  count of completed instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. The state enum is held in rv_pkg.
- Reset values: state FETCH, PC RESET_PC, instr 0, retired 0, fault 0, running 0. All strobes (imem_req, alu_start, dmem_req, dmem_we, rf_we) are 0.
- FETCH: imem_req=1. On imem_valid, latch imem_rdata into instr and go to DECODE.
- DECODE: if illegal, go to FAULT. Otherwise go to EXEC and pulse alu_start for exactly one cycle on entry to EXEC.
- EXEC: wait for alu_done. Then:
  - load/store go to MEM.
  - is_branch completes here.
  - is_alu goes to WB.
- MEM: dmem_req=1, dmem_we=is_store. On dmem_ack, a load goes to WB; a store completes.
- WB: rf_we=1 for one cycle, then the instruction completes.
- Completion:
  - PC update: PC <= (is_branch && branch_taken) ? branch_target : PC+4, mod 2**PC_WIDTH.
  - retired increments by 1 and wraps to 0.
  - Next state is HALT if halt_req is high, otherwise FETCH.
- A taken target with bits [1:0] != 0 goes to FAULT. In that case PC is not updated and retired is not incremented.
- Timeout: a wait counter clears on entering FETCH, EXEC or MEM and increments each cycle spent waiting in that state. When it reaches all-ones, go to FAULT.
- HALT: all requests are 0. When halt_req falls, go to FETCH with PC unchanged.
- FAULT: terminal until reset. fault=1 and all requests are 0.
- halt_req is ignored mid-instruction. It is sampled only at completion.

## Timing
- Memory handshake: req rises on state entry and stays high until the cycle valid/ack is sampled high, inclusive. A zero-wait response is allowed (valid in the first FETCH cycle). Responses arriving while req=0 are ignored.
- Minimum latency with zero-wait responses:
  - Branch: 3 cycles (FETCH, DECODE, EXEC).
  - ALU op: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- The retired increment and the PC update occur on the same edge as the completing state transition.
- Reset assertion mid-transaction forces all outputs to their reset values immediately (asynchronous); the pending access is abandoned.
- running rises the first cycle after reset release.

## Structure
- rv_pkg: state enum, instruction-class constants, PC_STEP=4. Shared with the decoder and the core top level.
- One sub-module, rv_wait_timer: TIMEOUT_W counter with clear, enable and expired outputs.

## Test plan
- Reset then zero-wait fetch of an ALU op: imem_addr=0, rf_we pulses in cycle 4, retired=1, next imem_addr=4.
- Load with dmem_ack delayed 3 cycles: dmem_req held for 4 cycles with dmem_we=0, rf_we once, total 8 cycles.
- Taken branch to 0x100: next imem_addr=0x100, no rf_we. Target 0x102: fault=1, running=0, retired unchanged.
- halt_req raised during EXEC: the instruction completes, retired increments, state is HALT. Dropping halt_req resumes fetch at PC+4.
- imem_valid held low with TIMEOUT_W=4: FAULT after 15 FETCH cycles. Illegal instruction goes to FAULT from DECODE.
- rst_n asserted while dmem_req=1: dmem_req drops immediately. After release, fetch restarts at RESET_PC with retired=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path.
// Used by the sequencer, the decoder and the core top level.
package rv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } seq_state_t;

    // Instruction classes as reported by the decoder's one-hot flags.
    localparam logic [3:0] CLS_ALU    = 4'b0001;
    localparam logic [3:0] CLS_LOAD   = 4'b0010;
    localparam logic [3:0] CLS_STORE  = 4'b0100;
    localparam logic [3:0] CLS_BRANCH = 4'b1000;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/rv_wait_timer.sv
// Wait-cycle counter for the sequencer's handshake states; flags the cycle
// in which the count would reach all-ones.
module rv_wait_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = {TIMEOUT_W{1'b1}} - 1'b1;

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Asserted on the wait cycle whose increment lands on all-ones.
    assign o_expired = i_enable && (r_count == LAST_WAIT);

endmodule

// File: rtl/rv_mc_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer: owns the PC,
// handshakes with imem, ALU and dmem, and counts retired instructions.
module rv_mc_sequencer
    import rv_pkg::*;
#(
    parameter int                PC_WIDTH  = 32,
    parameter int                I_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                RETIRE_W  = 32,
    parameter int                TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    input  logic                i_imem_valid,
    input  logic [I_WIDTH-1:0]  i_imem_rdata,
    output logic [I_WIDTH-1:0]  o_instr,
    input  logic                i_is_alu,
    input  logic                i_is_load,
    input  logic                i_is_store,
    input  logic                i_is_branch,
    input  logic                i_illegal,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    output logic                o_alu_start,
    input  logic                i_alu_done,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    input  logic                i_dmem_ack,
    output logic                o_rf_we,
    input  logic                i_halt_req,
    output logic                o_running,
    output logic                o_fault,
    output logic [RETIRE_W-1:0] o_retired
);

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [I_WIDTH-1:0]  r_instr;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_running;
    logic                r_alu_start;
    logic                w_complete;
    logic                w_retire;
    logic                w_wait;
    logic                w_expired;
    logic                w_take;
    logic                w_misaligned;

    assign w_take       = i_is_branch && i_branch_taken;
    assign w_misaligned = w_take && (i_branch_target[1:0] != 2'b00);

    rv_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_next != r_state),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_wait     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // The idle FETCH cycle straight after reset has no request out.
                if (r_running) begin
                    if (i_imem_valid) w_next = ST_DECODE;
                    else              w_wait = 1'b1;
                end
            end
            ST_DECODE: w_next = i_illegal ? ST_FAULT : ST_EXEC;
            ST_EXEC: begin
                if (i_alu_done) begin
                    if (i_is_load || i_is_store) w_next = ST_MEM;
                    else if (i_is_branch)        w_complete = 1'b1;
                    else if (i_is_alu)           w_next = ST_WB;
                    else                         w_complete = 1'b1;
                end else begin
                    w_wait = 1'b1;
                end
            end
            ST_MEM: begin
                if (i_dmem_ack) begin
                    if (i_is_store) w_complete = 1'b1;
                    else            w_next = ST_WB;
                end else begin
                    w_wait = 1'b1;
                end
            end
            ST_WB:    w_complete = 1'b1;
            ST_HALT:  if (!i_halt_req) w_next = ST_FETCH;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_FAULT;
        endcase
        if (w_complete) begin
            if (w_misaligned) w_next = ST_FAULT;
            else              w_next = i_halt_req ? ST_HALT : ST_FETCH;
        end
        if (w_expired) w_next = ST_FAULT;
    end

    assign w_retire = w_complete && !w_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_retired   <= '0;
            r_running   <= 1'b0;
            r_alu_start <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_running   <= (w_next != ST_HALT) && (w_next != ST_FAULT);
            r_alu_start <= (r_state == ST_DECODE) && !i_illegal;
            if ((r_state == ST_FETCH) && r_running && i_imem_valid) begin
                r_instr <= i_imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_take ? i_branch_target : r_pc + PC_WIDTH'(PC_STEP);
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign o_imem_req  = (r_state == ST_FETCH) && r_running;
    assign o_imem_addr = r_pc;
    assign o_instr     = r_instr;
    assign o_alu_start = r_alu_start;
    assign o_dmem_req  = (r_state == ST_MEM);
    assign o_dmem_we   = (r_state == ST_MEM) && i_is_store;
    assign o_rf_we     = (r_state == ST_WB);
    assign o_running   = r_running;
    assign o_fault     = (r_state == ST_FAULT);
    assign o_retired   = r_retired;

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed bench for rv_mc_sequencer: each task drives one scenario cycle by
// cycle and compares outputs against hand-derived values.
module tb_rv_mc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic        isAlu, isLoad, isStore, isBranch, illegal;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        aluStart;
    logic        aluDone;
    logic        dmemReq;
    logic        dmemWe;
    logic        dmemAck;
    logic        rfWe;
    logic        haltReq;
    logic        running;
    logic        fault;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    rv_mc_sequencer #(
        .PC_WIDTH (32),
        .I_WIDTH  (32),
        .RESET_PC (32'h0),
        .RETIRE_W (32),
        .TIMEOUT_W(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_imem_req     (imemReq),
        .o_imem_addr    (imemAddr),
        .i_imem_valid   (imemValid),
        .i_imem_rdata   (imemRdata),
        .o_instr        (instr),
        .i_is_alu       (isAlu),
        .i_is_load      (isLoad),
        .i_is_store     (isStore),
        .i_is_branch    (isBranch),
        .i_illegal      (illegal),
        .i_branch_taken (branchTaken),
        .i_branch_target(branchTarget),
        .o_alu_start    (aluStart),
        .i_alu_done     (aluDone),
        .o_dmem_req     (dmemReq),
        .o_dmem_we      (dmemWe),
        .i_dmem_ack     (dmemAck),
        .o_rf_we        (rfWe),
        .i_halt_req     (haltReq),
        .o_running      (running),
        .o_fault        (fault),
        .o_retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        imemValid = 0; imemRdata = 0;
        isAlu = 0; isLoad = 0; isStore = 0; isBranch = 0; illegal = 0;
        branchTaken = 0; branchTarget = 0;
        aluDone = 0; dmemAck = 0; haltReq = 0;
    endtask

    // Pulse reset, release it, and leave the bench in the first requesting FETCH cycle.
    task automatic applyReset();
        clearInputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n = 0;
        #3;
        checks++; if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_req got %b want 0", imemReq); end
        checks++; if (running !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got %b want 0", running); end
        checks++; if (fault !== 1'b0 || retired !== 32'd0 || instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_regs got fault=%b retired=%0d instr=%h want 0/0/0", fault, retired, instr); end
        checks++; if (aluStart !== 1'b0 || dmemReq !== 1'b0 || dmemWe !== 1'b0 || rfWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got alu=%b dreq=%b dwe=%b rfwe=%b want 0", aluStart, dmemReq, dmemWe, rfWe); end
        tick();
        rst_n = 1;
        tick();
        checks++; if (running !== 1'b1 || imemReq !== 1'b1 || imemAddr !== 32'h0) begin errors++; $display("[TB] FAIL post_reset got run=%b req=%b addr=%h want 1/1/0", running, imemReq, imemAddr); end
    endtask

    task automatic test_alu_op();
        imemValid = 1; imemRdata = 32'h00A00093; isAlu = 1;
        tick();
        imemValid = 0;
        checks++; if (instr !== 32'h00A00093) begin errors++; $display("[TB] FAIL alu_instr got %h want 00a00093", instr); end
        tick();
        checks++; if (aluStart !== 1'b1) begin errors++; $display("[TB] FAIL alu_start got %b want 1", aluStart); end
        aluDone = 1;
        tick();
        aluDone = 0;
        checks++; if (rfWe !== 1'b1 || aluStart !== 1'b0) begin errors++; $display("[TB] FAIL alu_wb got rfwe=%b alustart=%b want 1/0", rfWe, aluStart); end
        tick();
        checks++; if (retired !== 32'd1 || imemAddr !== 32'h4 || rfWe !== 1'b0) begin errors++; $display("[TB] FAIL alu_done got retired=%0d addr=%h rfwe=%b want 1/4/0", retired, imemAddr, rfWe); end
        isAlu = 0;
    endtask

    task automatic test_load_delayed();
        int reqCycles = 0;
        imemValid = 1; imemRdata = 32'h00412083; isLoad = 1;
        tick();
        imemValid = 0;
        tick();
        aluDone = 1;
        tick();
        aluDone = 0;
        for (int c = 1; c <= 4; c++) begin
            if (dmemReq === 1'b1 && dmemWe === 1'b0) reqCycles++;
            dmemAck = (c == 4);
            tick();
        end
        dmemAck = 0;
        checks++; if (reqCycles !== 4) begin errors++; $display("[TB] FAIL load_dmem_req got %0d cycles want 4", reqCycles); end
        checks++; if (rfWe !== 1'b1 || dmemReq !== 1'b0) begin errors++; $display("[TB] FAIL load_wb got rfwe=%b dreq=%b want 1/0", rfWe, dmemReq); end
        tick();
        checks++; if (rfWe !== 1'b0 || retired !== 32'd2 || imemAddr !== 32'h8) begin errors++; $display("[TB] FAIL load_done got rfwe=%b retired=%0d addr=%h want 0/2/8", rfWe, retired, imemAddr); end
        isLoad = 0;
    endtask

    task automatic test_branch();
        int rfSeen = 0;
        imemValid = 1; isBranch = 1;
        tick();
        imemValid = 0;
        tick();
        aluDone = 1; branchTaken = 1; branchTarget = 32'h100;
        if (rfWe !== 1'b0) rfSeen++;
        tick();
        aluDone = 0;
        checks++; if (imemAddr !== 32'h100 || retired !== 32'd3 || imemReq !== 1'b1 || rfSeen !== 0) begin errors++; $display("[TB] FAIL branch_taken got addr=%h retired=%0d req=%b rf=%0d want 100/3/1/0", imemAddr, retired, imemReq, rfSeen); end
        imemValid = 1; branchTaken = 0;
        tick();
        imemValid = 0;
        tick();
        aluDone = 1; branchTaken = 1; branchTarget = 32'h102;
        tick();
        aluDone = 0;
        checks++; if (fault !== 1'b1 || running !== 1'b0 || retired !== 32'd3 || imemReq !== 1'b0) begin errors++; $display("[TB] FAIL branch_misaligned got fault=%b run=%b retired=%0d req=%b want 1/0/3/0", fault, running, retired, imemReq); end
        tick();
        checks++; if (fault !== 1'b1 || imemAddr !== 32'h100) begin errors++; $display("[TB] FAIL fault_sticky got fault=%b addr=%h want 1/100", fault, imemAddr); end
    endtask

    task automatic test_halt();
        applyReset();
        imemValid = 1; isAlu = 1;
        tick();
        imemValid = 0;
        tick();
        haltReq = 1; aluDone = 1;
        tick();
        aluDone = 0;
        tick();
        checks++; if (retired !== 32'd1 || running !== 1'b0 || imemReq !== 1'b0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL halt_enter got retired=%0d run=%b req=%b fault=%b want 1/0/0/0", retired, running, imemReq, fault); end
        tick();
        checks++; if (running !== 1'b0 || imemReq !== 1'b0) begin errors++; $display("[TB] FAIL halt_hold got run=%b req=%b want 0/0", running, imemReq); end
        haltReq = 0;
        tick();
        checks++; if (running !== 1'b1 || imemReq !== 1'b1 || imemAddr !== 32'h4) begin errors++; $display("[TB] FAIL halt_resume got run=%b req=%b addr=%h want 1/1/4", running, imemReq, imemAddr); end
        isAlu = 0;
    endtask

    task automatic test_timeout();
        for (int c = 1; c < 15; c++) tick();
        checks++; if (fault !== 1'b0 || imemReq !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early got fault=%b req=%b want 0/1", fault, imemReq); end
        tick();
        checks++; if (fault !== 1'b1 || running !== 1'b0) begin errors++; $display("[TB] FAIL timeout_fault got fault=%b run=%b want 1/0", fault, running); end
    endtask

    task automatic test_illegal();
        applyReset();
        imemValid = 1; illegal = 1;
        tick();
        imemValid = 0;
        checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL illegal_decode got fault=%b want 0", fault); end
        tick();
        checks++; if (fault !== 1'b1 || aluStart !== 1'b0 || retired !== 32'd0) begin errors++; $display("[TB] FAIL illegal_fault got fault=%b alustart=%b retired=%0d want 1/0/0", fault, aluStart, retired); end
        illegal = 0;
    endtask

    task automatic test_back_to_back();
        applyReset();
        imemValid = 1; isStore = 1;
        tick();
        imemValid = 0;
        tick();
        aluDone = 1;
        tick();
        aluDone = 0;
        checks++; if (dmemReq !== 1'b1 || dmemWe !== 1'b1) begin errors++; $display("[TB] FAIL store_mem got dreq=%b dwe=%b want 1/1", dmemReq, dmemWe); end
        dmemAck = 1;
        tick();
        dmemAck = 0;
        checks++; if (retired !== 32'd1 || imemAddr !== 32'h4 || dmemReq !== 1'b0) begin errors++; $display("[TB] FAIL store_done got retired=%0d addr=%h dreq=%b want 1/4/0", retired, imemAddr, dmemReq); end
        imemValid = 1;
        tick();
        imemValid = 0;
        tick();
        aluDone = 1;
        tick();
        aluDone = 0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (dmemReq !== 1'b0 || dmemWe !== 1'b0 || running !== 1'b0 || retired !== 32'd0) begin errors++; $display("[TB] FAIL async_reset got dreq=%b dwe=%b run=%b retired=%0d want 0/0/0/0", dmemReq, dmemWe, running, retired); end
        clearInputs();
        tick();
        rst_n = 1;
        tick();
        checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0 || retired !== 32'd0) begin errors++; $display("[TB] FAIL restart got req=%b addr=%h retired=%0d want 1/0/0", imemReq, imemAddr, retired); end
    endtask

    initial begin
        rst_n = 1;
        clearInputs();
        #2;
        test_reset();
        test_alu_op();
        test_load_delayed();
        test_branch();
        test_halt();
        test_timeout();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
